apb_slave_regfile: RTL and testbench

Parametrised APB4 completer exposing a bank of `NUM_REGS` read/write registers with byte strobes, a configurable wait-state count and error signalling. It sits behind one `psel` bit of the APB decoder. It is the generic successor to the fixed-width APB bus definition: widths, depth, latency and protection checking are all parameters. Register contents are exported to the owning subsystem as a flat vector with per-register write pulses.

---
 rtl/apb_slave_pkg.sv | 34 +++
 rtl/apb_strb_reg.sv | 24 ++
 rtl/apb_slave_regfile.sv | 125 ++++++++++++
 tb/tb_apb_slave_regfile.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_pkg.sv
// Shared types and address decode helpers for the APB register-file completer.
package apb_slave_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    function automatic int idx_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    function automatic logic [63:0] addr_to_idx(input logic [63:0] addr,
                                                input logic [63:0] base,
                                                input int          strb_lg2);
        return (addr - base) >> strb_lg2;
    endfunction

    // Out-of-window, misaligned or non-secure (when forbidden) accesses all error.
    function automatic logic addr_err(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input int          num_regs,
                                      input int          strb_lg2,
                                      input logic        secure_only,
                                      input logic [2:0]  prot);
        logic [63:0] mask;
        mask = (64'd1 << strb_lg2) - 64'd1;
        return (addr < base)
            || (addr_to_idx(addr, base, strb_lg2) >= 64'(num_regs))
            || ((addr & mask) != 64'd0)
            || (secure_only && prot[1]);
    endfunction

endpackage

// File: rtl/apb_strb_reg.sv
// One data register with per-byte write enables and a parametrised reset value.
module apb_strb_reg #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] strb,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   q
);

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            q <= RESET_VAL;
        end else if (we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (strb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB4 completer: bank of byte-strobed registers with wait states and error response.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0,
    parameter bit                    SECURE_ONLY = 1'b0
) (
    input  logic                             pclk,
    input  logic                             preset,
    input  logic                             psel,
    input  logic                             penable,
    input  logic                             pwrite,
    input  logic [ADDR_WIDTH-1:0]            paddr,
    input  logic [DATA_WIDTH-1:0]            pwdata,
    input  logic [DATA_WIDTH/8-1:0]          pstrb,
    input  logic [2:0]                       pprot,
    output logic                             pready,
    output logic [DATA_WIDTH-1:0]            prdata,
    output logic                             pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_q,
    output logic [NUM_REGS-1:0]              wr_pulse
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int STRB_LG2   = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
    localparam int IDX_W      = idx_width(NUM_REGS);

    state_t                  state, state_n;
    logic [3:0]              cnt, cnt_n;
    logic                    pready_n;
    logic [DATA_WIDTH-1:0]   prdata_n;
    logic                    pslverr_n;
    logic                    setup;
    logic                    commit;
    logic                    err;
    logic [63:0]             idx_full;
    logic [IDX_W-1:0]        idx;
    logic [NUM_REGS-1:0]     we;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

    assign idx_full = addr_to_idx(64'(paddr), 64'(BASE_ADDR), STRB_LG2);
    assign idx      = idx_full[IDX_W-1:0];
    assign err      = addr_err(64'(paddr), 64'(BASE_ADDR), NUM_REGS, STRB_LG2,
                               SECURE_ONLY, pprot);
    assign setup    = psel && !penable;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        pready_n = 1'b0;
        case (state)
            IDLE: begin
                if (setup) begin
                    state_n  = ACCESS;
                    cnt_n    = 4'(WAIT_STATES);
                    pready_n = (WAIT_STATES == 0);
                end
            end
            ACCESS: begin
                if (!pready) begin
                    // Deselect mid-wait is a protocol violation: drop the transfer.
                    if (!psel) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n    = cnt - 4'd1;
                        pready_n = (cnt == 4'd1);
                    end
                end else if (setup) begin
                    cnt_n    = 4'(WAIT_STATES);
                    pready_n = (WAIT_STATES == 0);
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Response is captured on the edge that raises pready.
        prdata_n  = (pready_n && !pwrite && !err) ? regs[idx] : '0;
        pslverr_n = pready_n && err;
        commit    = (state == ACCESS) && pready && psel && penable && pwrite && !err;
        for (int i = 0; i < NUM_REGS; i++) begin
            we[i] = commit && (idx == IDX_W'(i)) && (|pstrb);
        end
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state    <= IDLE;
            cnt      <= '0;
            pready   <= 1'b0;
            prdata   <= '0;
            pslverr  <= 1'b0;
            wr_pulse <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pready   <= pready_n;
            prdata   <= prdata_n;
            pslverr  <= pslverr_n;
            wr_pulse <= we;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        apb_strb_reg #(
            .DATA_WIDTH (DATA_WIDTH),
            .RESET_VAL  (RESET_VAL)
        ) u_reg (
            .pclk   (pclk),
            .preset (preset),
            .we     (we[g]),
            .strb   (pstrb),
            .wdata  (pwdata),
            .q      (regs[g])
        );
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed and randomized bench for apb_slave_regfile across three parameter sets.
module tb_apb_slave_regfile;

    logic          pclk = 1'b0;
    logic [2:0]    rstn;
    logic [2:0]    sel;
    logic          penable;
    logic          pwrite;
    logic [31:0]   paddr;
    logic [31:0]   pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;

    logic          pready   [3];
    logic [31:0]   prdata   [3];
    logic          pslverr  [3];
    logic [511:0]  reg_q    [3];
    logic [15:0]   wr_pulse [3];

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;

    logic [31:0]   mdl [3][16];
    int            ws  [3] = '{0, 3, 2};
    bit            sec [3] = '{1'b0, 1'b1, 1'b0};

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc++;

    apb_slave_regfile #(.BASE_ADDR(32'h100), .WAIT_STATES(0), .SECURE_ONLY(1'b0),
                        .RESET_VAL(32'h0)) dut0 (
        .pclk(pclk), .preset(rstn[0]), .psel(sel[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]),
        .reg_q(reg_q[0]), .wr_pulse(wr_pulse[0]));

    apb_slave_regfile #(.BASE_ADDR(32'h100), .WAIT_STATES(3), .SECURE_ONLY(1'b1),
                        .RESET_VAL(32'h0)) dut1 (
        .pclk(pclk), .preset(rstn[1]), .psel(sel[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]),
        .reg_q(reg_q[1]), .wr_pulse(wr_pulse[1]));

    apb_slave_regfile #(.BASE_ADDR(32'h100), .WAIT_STATES(2), .SECURE_ONLY(1'b0),
                        .RESET_VAL(32'hA5A5_A5A5)) dut2 (
        .pclk(pclk), .preset(rstn[2]), .psel(sel[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready[2]), .prdata(prdata[2]), .pslverr(pslverr[2]),
        .reg_q(reg_q[2]), .wr_pulse(wr_pulse[2]));

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] pack(input int d);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = mdl[d][i];
        return v;
    endfunction

    // One complete APB transfer, entered and left at a falling edge.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdat, input logic [3:0] strb,
                        input logic [2:0] prot, output logic [31:0] rd);
        logic        exp_err;
        logic [31:0] off;
        logic [31:0] exp_rd;
        logic [15:0] exp_pulse;
        int          idx;
        int          w;
        off     = (addr - 32'h100) >> 2;
        exp_err = (addr < 32'h100) || (addr[1:0] != 2'b00) || (sec[d] && prot[1])
                  || (off >= 32'd16);
        idx     = int'(off[3:0]);
        exp_rd  = (!wr && !exp_err) ? mdl[d][idx] : 32'h0;

        sel      = 3'b000;
        sel[d]   = 1'b1;
        penable  = 1'b0;
        pwrite   = wr;
        paddr    = addr;
        pwdata   = wdat;
        pstrb    = strb;
        pprot    = prot;
        @(negedge pclk);
        penable = 1'b1;
        w = 0;
        while (!pready[d] && w < 40) begin
            chk("wait_prdata", 512'(prdata[d]), 512'h0);
            chk("wait_pslverr", 512'(pslverr[d]), 512'h0);
            @(negedge pclk);
            w++;
        end
        chk("wait_count", 512'(w), 512'(ws[d]));
        chk("pslverr", 512'(pslverr[d]), 512'(exp_err));
        chk("prdata", 512'(prdata[d]), 512'(exp_rd));
        rd = prdata[d];

        exp_pulse = 16'h0;
        if (wr && !exp_err && strb != 4'h0) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[d][idx][b*8 +: 8] = wdat[b*8 +: 8];
            exp_pulse[idx] = 1'b1;
        end
        @(negedge pclk);
        chk("wr_pulse", 512'(wr_pulse[d]), 512'(exp_pulse));
        chk("reg_q", reg_q[d], pack(d));
    endtask

    task automatic idle(input int n);
        sel     = 3'b000;
        penable = 1'b0;
        repeat (n) @(negedge pclk);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int          c0;

        rstn = 3'b000; sel = 3'b000; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 16; i++)
                mdl[d][i] = (d == 2) ? 32'hA5A5_A5A5 : 32'h0;
        repeat (3) @(negedge pclk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_pready", 512'(pready[d]), 512'h0);
            chk("rst_prdata", 512'(prdata[d]), 512'h0);
            chk("rst_pslverr", 512'(pslverr[d]), 512'h0);
            chk("rst_wr_pulse", 512'(wr_pulse[d]), 512'h0);
            chk("rst_reg_q", reg_q[d], pack(d));
        end
        rstn = 3'b111;
        idle(2);

        // Zero-wait write, then byte-strobe merge and read-back.
        xfer(0, 1'b1, 32'h104, 32'hDEADBEEF, 4'hF, 3'b000, rd);
        chk("reg1_slice", 512'(reg_q[0][63:32]), 512'h0DEADBEEF);
        chk("reg1_pulse", 512'(wr_pulse[0]), 512'h0002);
        idle(1);
        chk("pulse_one_cycle", 512'(wr_pulse[0]), 512'h0);
        xfer(0, 1'b1, 32'h104, 32'h11223344, 4'h5, 3'b000, rd);
        idle(1);
        xfer(0, 1'b0, 32'h104, 32'h0, 4'h0, 3'b000, rd);
        chk("merge_read", 512'(rd), 512'hDE22BE44);
        idle(1);

        // Error cases and strobe-free write.
        xfer(0, 1'b0, 32'h140, 32'h0, 4'hF, 3'b000, rd);
        idle(1);
        xfer(0, 1'b1, 32'h102, 32'hFFFFFFFF, 4'hF, 3'b000, rd);
        idle(1);
        xfer(0, 1'b1, 32'h0FC, 32'hFFFFFFFF, 4'hF, 3'b000, rd);
        idle(1);
        xfer(0, 1'b1, 32'h108, 32'h12345678, 4'h0, 3'b000, rd);
        idle(1);

        // Back-to-back zero-wait writes: one transfer every two cycles.
        c0 = cyc;
        for (int k = 0; k < 4; k++)
            xfer(0, 1'b1, 32'h110 + 32'(4*k), 32'hA000_0000 + 32'(k), 4'hF, 3'b000, rd);
        chk("b2b_cycles", 512'(cyc - c0), 512'd8);
        idle(1);

        // Wait-state read and secure-only filtering.
        xfer(1, 1'b1, 32'h10C, 32'hCAFEF00D, 4'hF, 3'b000, rd);
        idle(1);
        xfer(1, 1'b0, 32'h10C, 32'h0, 4'h0, 3'b000, rd);
        chk("ws3_read", 512'(rd), 512'hCAFEF00D);
        idle(1);
        xfer(1, 1'b1, 32'h10C, 32'h55555555, 4'hF, 3'b010, rd);
        idle(1);
        xfer(1, 1'b0, 32'h10C, 32'h0, 4'h0, 3'b101, rd);
        chk("secure_ok_read", 512'(rd), 512'hCAFEF00D);
        idle(1);

        // Reset asserted in the completion cycle of a two-wait write.
        sel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h108;
        pwdata = 32'h12345678; pstrb = 4'hF; pprot = 3'b000;
        @(negedge pclk);
        penable = 1'b1;
        chk("mid_pready_a", 512'(pready[2]), 512'h0);
        @(negedge pclk);
        chk("mid_pready_b", 512'(pready[2]), 512'h0);
        @(negedge pclk);
        chk("mid_pready_c", 512'(pready[2]), 512'h1);
        #2 rstn[2] = 1'b0;
        #1;
        chk("async_pready", 512'(pready[2]), 512'h0);
        chk("async_prdata", 512'(prdata[2]), 512'h0);
        chk("async_pslverr", 512'(pslverr[2]), 512'h0);
        chk("async_wr_pulse", 512'(wr_pulse[2]), 512'h0);
        @(negedge pclk);
        idle(2);
        chk("abort_reg_q", reg_q[2], pack(2));
        rstn[2] = 1'b1;
        idle(1);
        xfer(2, 1'b1, 32'h108, 32'h0BADF00D, 4'hC, 3'b000, rd);
        idle(1);

        // Randomized traffic against the reference model.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 25; n++) begin
                a = 32'h0F8 + 32'($urandom_range(0, 32'h50));
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                     3'($urandom_range(0, 7)), rd);
                if ($urandom_range(0, 1) == 1) idle(1);
            end
            idle(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
